// File: rtl/dht11_pkg.sv
// Shared constants for the DHT11 responder: FSM state encoding, phase lengths in microseconds, frame width.
// Optional checksum fault injection is enabled by defining DHT11_FAULT_INJ_EN.
package dht11_pkg;

  typedef logic [2:0] state_t;

  // state  | meaning
  // IDLE   | line released, waiting for host low
  // START  | measuring host low time
  // WAIT   | start accepted, bytes snapshotted, response delay
  // ACK_LO | acknowledge low
  // ACK_HI | acknowledge high
  // BIT_LO | bit preamble low
  // BIT_HI | bit high, length encodes the bit value
  // END_LO | trailing low, then release and report done
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_ACK_LO = 3'd3;
  localparam state_t S_ACK_HI = 3'd4;
  localparam state_t S_BIT_LO = 3'd5;
  localparam state_t S_BIT_HI = 3'd6;
  localparam state_t S_END_LO = 3'd7;

  localparam logic [15:0] US_ACK       = 16'd80;
  localparam logic [15:0] US_BIT_LO    = 16'd50;
  localparam logic [15:0] US_BIT0      = 16'd26;
  localparam logic [15:0] US_BIT1      = 16'd70;
  localparam int          US_RESP_WAIT = 30;

  localparam int FRAME_BITS = 40;

  function automatic logic [15:0] phase_us(input state_t st, input logic bit_v,
                                           input logic [15:0] wait_us);
    case (st)
      S_WAIT:             return wait_us;
      S_ACK_LO, S_ACK_HI: return US_ACK;
      S_BIT_LO, S_END_LO: return US_BIT_LO;
      S_BIT_HI:           return bit_v ? US_BIT1 : US_BIT0;
      default:            return 16'd1;
    endcase
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US cycles, restarted by i_clr.
module dht11_us_tick #(
  parameter int CLK_PER_US = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_US - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= LAST;
    end else if (i_clr || o_tick) begin
      r_cnt <= LAST;
    end else begin
      r_cnt <= r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: qualifies a host start pulse, then sends acknowledge and a 40-bit frame.
// Defining DHT11_FAULT_INJ_EN adds Chk_Flip, which inverts checksum bit 0 when sampled high.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CLK_PER_US   = 20,
  parameter int START_MIN_US = 17000,
  parameter int RESP_WAIT_US = US_RESP_WAIT
) (
  input  logic       CLK,
  input  logic       RST,
  inout  wire        Pin_Data,
  input  logic [7:0] RH_Int,
  input  logic [7:0] RH_Dec,
  input  logic [7:0] T_Int,
  input  logic [7:0] T_Dec,
  output logic       Busy,
  output logic       Done
`ifdef DHT11_FAULT_INJ_EN
  ,
  input  logic       Chk_Flip
`endif
);

  localparam logic [15:0] START_MIN = 16'(START_MIN_US);
  localparam logic [15:0] RESP_WAIT = 16'(RESP_WAIT_US);
  localparam logic [5:0]  LAST_BIT  = 6'(FRAME_BITS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1, r_sync2;
  logic [15:0] r_tmr;
  logic [15:0] r_low_us;
  logic [15:0] w_low_eff;
  logic [5:0]  r_bit_idx;
  logic [39:0] r_frame;
  logic        r_oe, r_out, r_busy, r_done;
  logic        w_tick, w_clr, w_phase_end, w_bit, w_low_ok;
  logic [7:0]  w_chk, w_chk_tx;

  dht11_us_tick #(.CLK_PER_US(CLK_PER_US)) u_us_tick (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  assign Pin_Data = r_oe ? r_out : 1'bz;
  assign Busy     = r_busy;
  assign Done     = r_done;

  // Synchronizer is held idle-high while we drive, so our own trailing low never looks like a host start.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else if (r_oe) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Pin_Data;
      r_sync2 <= r_sync1;
    end
  end

  assign w_chk = RH_Int + RH_Dec + T_Int + T_Dec;
`ifdef DHT11_FAULT_INJ_EN
  assign w_chk_tx = w_chk ^ {7'd0, Chk_Flip};
`else
  assign w_chk_tx = w_chk;
`endif

  assign w_bit       = r_frame[LAST_BIT - r_bit_idx];
  assign w_phase_end = w_tick && (r_tmr == '0);
  // Include the tick landing on the release edge so a low of exactly N us measures N.
  assign w_low_eff   = (w_tick && (r_low_us != 16'hFFFF)) ? r_low_us + 16'd1 : r_low_us;
  assign w_low_ok    = (w_low_eff >= START_MIN);
  assign w_clr       = (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!r_sync2)    w_state_nxt = S_START;
      S_START:  if (r_sync2)     w_state_nxt = w_low_ok ? S_WAIT : S_IDLE;
      S_WAIT:   if (w_phase_end) w_state_nxt = S_ACK_LO;
      S_ACK_LO: if (w_phase_end) w_state_nxt = S_ACK_HI;
      S_ACK_HI: if (w_phase_end) w_state_nxt = S_BIT_LO;
      S_BIT_LO: if (w_phase_end) w_state_nxt = S_BIT_HI;
      S_BIT_HI: if (w_phase_end) w_state_nxt = (r_bit_idx == LAST_BIT) ? S_END_LO : S_BIT_LO;
      S_END_LO: if (w_phase_end) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_low_us  <= '0;
      r_bit_idx <= '0;
      r_frame   <= '0;
      r_oe      <= 1'b0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      r_oe    <= (w_state_nxt inside {S_ACK_LO, S_ACK_HI, S_BIT_LO, S_BIT_HI, S_END_LO});
      r_out   <= (w_state_nxt == S_ACK_HI) || (w_state_nxt == S_BIT_HI);

      if (w_clr)                           r_tmr <= phase_us(w_state_nxt, w_bit, RESP_WAIT) - 16'd1;
      else if (w_tick && (r_tmr != '0))    r_tmr <= r_tmr - 16'd1;

      if (w_clr)                           r_low_us <= '0;
      else if (r_state == S_START)         r_low_us <= w_low_eff;

      if ((r_state == S_START) && (w_state_nxt == S_WAIT)) begin
        r_frame   <= {RH_Int, RH_Dec, T_Int, T_Dec, w_chk_tx};
        r_bit_idx <= '0;
        r_busy    <= 1'b1;
      end
      if ((r_state == S_BIT_HI) && (w_state_nxt == S_BIT_LO)) r_bit_idx <= r_bit_idx + 6'd1;
      if ((r_state == S_END_LO) && (w_state_nxt == S_IDLE)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder; runs at 2 clocks/us and a 40 us start minimum to keep frames short.
module tb_dht11_responder;

  localparam int C    = 2;
  localparam int SMIN = 40;
  localparam int LAT  = 30 * C + 3;  // negedges from release to first observed drive-low

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       r_host_low = 1'b0;
  logic [7:0] rh_int = 8'd0, rh_dec = 8'd0, t_int = 8'd0, t_dec = 8'd0;
  logic       Busy, Done;
  wire        Pin_Data;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
`ifdef DHT11_FAULT_INJ_EN
  logic       chk_flip = 1'b0;
`endif

  assign Pin_Data = r_host_low ? 1'b0 : 1'bz;
  pullup pu_pin (Pin_Data);

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (Done === 1'b1) done_cnt++;

  dht11_responder #(.CLK_PER_US(C), .START_MIN_US(SMIN), .RESP_WAIT_US(30)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Pin_Data (Pin_Data),
    .RH_Int   (rh_int),
    .RH_Dec   (rh_dec),
    .T_Int    (t_int),
    .T_Dec    (t_dec),
    .Busy     (Busy),
    .Done     (Done)
`ifdef DHT11_FAULT_INJ_EN
    ,
    .Chk_Flip (chk_flip)
`endif
  );

  task automatic set_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    rh_int = a; rh_dec = b; t_int = c; t_dec = d;
  endtask

  task automatic host_start(input int us);
    @(negedge CLK);
    r_host_low = 1'b1;
    repeat (us * C) @(negedge CLK);
    r_host_low = 1'b0;
    #1;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (Pin_Data !== 1'b0 && n < 500) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic meas(input logic lvl, output int n);
    n = 0;
    while (Pin_Data === lvl && n < 2000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  // Decodes a frame purely from pulse widths; any width off its nominal value counts as bad.
  task automatic rx_frame(output logic [39:0] f, output int ack_lo, output int ack_hi, output int bad);
    int lo, hi;
    f = '0;
    bad = 0;
    meas(1'b0, ack_lo);
    meas(1'b1, ack_hi);
    for (int i = 0; i < 40; i++) begin
      meas(1'b0, lo);
      meas(1'b1, hi);
      if (lo != 50 * C) bad++;
      if (hi == 70 * C) f = {f[38:0], 1'b1};
      else begin
        f = {f[38:0], 1'b0};
        if (hi != 26 * C) bad++;
      end
    end
    meas(1'b0, lo);
    if (lo != 50 * C) bad++;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (Pin_Data !== 1'b1) begin errors++; $display("FAIL reset_pin got %b want 1 (released)", Pin_Data); end
    RST = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [39:0] f;
    int n, alo, ahi, bad, d0;
    set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
    d0 = done_cnt;
    host_start(45);
    wait_ack(n);
    checks++; if (n != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", n, LAT); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hi got %b want 1", Busy); end
    rx_frame(f, alo, ahi, bad);
    checks++; if (alo != 80 * C) begin errors++; $display("FAIL basic_ack_lo got %0d want %0d", alo, 80 * C); end
    checks++; if (ahi != 80 * C) begin errors++; $display("FAIL basic_ack_hi got %0d want %0d", ahi, 80 * C); end
    checks++; if (f[39:8] !== 32'h37001900) begin errors++; $display("FAIL basic_data got %h want 37001900", f[39:8]); end
    checks++; if (f[7:0] !== 8'h50) begin errors++; $display("FAIL basic_chk got %h want 50", f[7:0]); end
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_widths got %0d bad want 0", bad); end
    repeat (3) @(negedge CLK);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d pulses want 1", done_cnt - d0); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_lo got %b want 0", Busy); end
  endtask

  task automatic test_boundary();
    logic [39:0] f;
    int n, alo, ahi, bad, saw_drive, saw_busy;
    set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
    saw_drive = 0;
    saw_busy = 0;
    host_start(SMIN - 1);
    repeat (LAT + 400) begin
      @(negedge CLK);
      if (Pin_Data !== 1'b1) saw_drive++;
      if (Busy !== 1'b0) saw_busy++;
    end
    checks++; if (saw_drive != 0) begin errors++; $display("FAIL short_no_drive got %0d driven cycles want 0", saw_drive); end
    checks++; if (saw_busy != 0) begin errors++; $display("FAIL short_no_busy got %0d busy cycles want 0", saw_busy); end
    host_start(SMIN);
    wait_ack(n);
    checks++; if (n != LAT) begin errors++; $display("FAIL exact_latency got %0d want %0d", n, LAT); end
    rx_frame(f, alo, ahi, bad);
    checks++; if (f !== 40'h3700190050) begin errors++; $display("FAIL exact_frame got %h want 3700190050", f); end
    checks++; if (bad != 0) begin errors++; $display("FAIL exact_widths got %0d bad want 0", bad); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_wrap();
    logic [39:0] f;
    int n, alo, ahi, bad;
    set_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    host_start(45);
    wait_ack(n);
    rx_frame(f, alo, ahi, bad);
    checks++; if (f !== 40'hFFFFFFFFFC) begin errors++; $display("FAIL wrap_frame got %h want fffffffffc", f); end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_widths got %0d bad want 0", bad); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_snapshot();
    logic [39:0] f;
    int n, alo, ahi, bad;
    set_bytes(8'hA5, 8'h5A, 8'h3C, 8'hC3);
    host_start(45);
    wait_ack(n);
    // 1400 cycles after acknowledge start lands inside the BIT_HI of bit 5 (window 1356..1495).
    fork
      rx_frame(f, alo, ahi, bad);
      begin
        repeat (1400) @(negedge CLK);
        set_bytes(8'h00, 8'h11, 8'h22, 8'h33);
      end
    join
    checks++; if (f !== 40'hA55A3CC3FE) begin errors++; $display("FAIL snapshot_frame got %h want a55a3cc3fe", f); end
    checks++; if (bad != 0) begin errors++; $display("FAIL snapshot_widths got %0d bad want 0", bad); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    logic [39:0] f;
    int n, alo, ahi, bad;
    set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
    host_start(45);
    wait_ack(n);
    repeat (80 * C + 20) @(negedge CLK);
    checks++; if (Pin_Data !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL midrst_in_ack_hi got pin %b busy %b want 1 1", Pin_Data, Busy); end
    RST = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", Busy); end
    r_host_low = 1'b1;
    #1;
    checks++; if (Pin_Data !== 1'b0) begin errors++; $display("FAIL midrst_released got %b want 0 (host only)", Pin_Data); end
    r_host_low = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (10) @(negedge CLK);
    host_start(45);
    wait_ack(n);
    checks++; if (n != LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", n, LAT); end
    rx_frame(f, alo, ahi, bad);
    checks++; if (f !== 40'h3700190050) begin errors++; $display("FAIL midrst_frame got %h want 3700190050", f); end
    repeat (3) @(negedge CLK);
  endtask

`ifdef DHT11_FAULT_INJ_EN
  task automatic test_fault();
    logic [39:0] f;
    int n, alo, ahi, bad;
    set_bytes(8'h37, 8'h00, 8'h19, 8'h00);
    chk_flip = 1'b1;
    host_start(45);
    wait_ack(n);
    chk_flip = 1'b0;
    rx_frame(f, alo, ahi, bad);
    checks++; if (f !== 40'h3700190051) begin errors++; $display("FAIL fault_frame got %h want 3700190051", f); end
    repeat (3) @(negedge CLK);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_wrap();
    test_snapshot();
    test_reset_mid();
`ifdef DHT11_FAULT_INJ_EN
    test_fault();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
